reg_write_arbiter: RTL and testbench

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/general_defs_pkg.sv | 13 +
 rtl/reg_write_slot.sv | 43 ++++
 rtl/reg_write_arbiter.sv | 133 +++++++++++++
 tb/tb_reg_write_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/general_defs_pkg.sv
// Shared definitions for the register-file write path: default widths and
// the round-robin grant state used by reg_write_arbiter.
package general_defs;

  localparam int unsigned ADDR_WIDTH = 4;
  localparam int unsigned WORD       = 32;

  typedef enum logic {
    LAST_ALU = 1'b0,
    LAST_MEM = 1'b1
  } grant_state_t;

endpackage

// File: rtl/reg_write_slot.sv
// One-entry holding slot for a single writeback requester. The slot refills
// in the same cycle it is granted, so a lone requester sustains one write per cycle.
module reg_write_slot #(
  parameter int unsigned ADDR_WIDTH = general_defs::ADDR_WIDTH,
  parameter int unsigned WORD       = general_defs::WORD
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WORD-1:0]       data_i,
  input  logic                  grant_i,
  input  logic                  age_i,
  output logic                  load_o,
  output logic                  full_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [WORD-1:0]       data_o,
  output logic                  age_o
);

  assign ready_o = !rst_i && (!full_o || grant_i);
  assign load_o  = valid_i && ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_o <= 1'b0;
      addr_o <= '0;
      data_o <= '0;
      age_o  <= 1'b0;
    end else begin
      age_o <= age_i;
      if (load_o) begin
        full_o <= 1'b1;
        addr_o <= addr_i;
        data_o <= data_i;
      end else if (grant_i) begin
        full_o <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Merges ALU and load-return writebacks onto the single register-file write
// port: round-robin between slots, oldest-first when both target one register.
module reg_write_arbiter
  import general_defs::grant_state_t, general_defs::LAST_ALU, general_defs::LAST_MEM;
#(
  parameter int unsigned ADDR_WIDTH = general_defs::ADDR_WIDTH,
  parameter int unsigned WORD       = general_defs::WORD
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     alu_valid_i,
  output logic                     alu_ready_o,
  input  logic [ADDR_WIDTH-1:0]    alu_addr_i,
  input  logic [WORD-1:0]          alu_data_i,
  input  logic                     mem_valid_i,
  output logic                     mem_ready_o,
  input  logic [ADDR_WIDTH-1:0]    mem_addr_i,
  input  logic [WORD-1:0]          mem_data_i,
  output logic                     write_en_o,
  output logic [ADDR_WIDTH-1:0]    write_addr_o,
  output logic [WORD-1:0]          write_data_o,
  output logic [2**ADDR_WIDTH-1:0] pending_mask_o,
  output logic                     idle_o
);

  grant_state_t          state_q;
  logic                  alu_full, mem_full;
  logic [ADDR_WIDTH-1:0] alu_addr_q, mem_addr_q;
  logic [WORD-1:0]       alu_data_q, mem_data_q;
  logic                  alu_age, mem_age, alu_age_n, mem_age_n;
  logic                  alu_load, mem_load;
  logic                  grant_alu, grant_mem;

  reg_write_slot #(.ADDR_WIDTH(ADDR_WIDTH), .WORD(WORD)) u_alu_slot (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (alu_valid_i),
    .ready_o (alu_ready_o),
    .addr_i  (alu_addr_i),
    .data_i  (alu_data_i),
    .grant_i (grant_alu),
    .age_i   (alu_age_n),
    .load_o  (alu_load),
    .full_o  (alu_full),
    .addr_o  (alu_addr_q),
    .data_o  (alu_data_q),
    .age_o   (alu_age)
  );

  reg_write_slot #(.ADDR_WIDTH(ADDR_WIDTH), .WORD(WORD)) u_mem_slot (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (mem_valid_i),
    .ready_o (mem_ready_o),
    .addr_i  (mem_addr_i),
    .data_i  (mem_data_i),
    .grant_i (grant_mem),
    .age_i   (mem_age_n),
    .load_o  (mem_load),
    .full_o  (mem_full),
    .addr_o  (mem_addr_q),
    .data_o  (mem_data_q),
    .age_o   (mem_age)
  );

  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (alu_full && mem_full) begin
      if (alu_addr_q == mem_addr_q) begin
        grant_alu = alu_age;
        grant_mem = !alu_age;
      end else begin
        grant_alu = (state_q == LAST_MEM);
        grant_mem = (state_q == LAST_ALU);
      end
    end else begin
      grant_alu = alu_full;
      grant_mem = mem_full;
    end
  end

  // Age bit set means "older than the other slot's entry"; it is only
  // meaningful while both slots are full, so an entry loaded beside a held
  // entry is younger, and simultaneous loads make the ALU entry older.
  always_comb begin
    alu_age_n = alu_age;
    mem_age_n = mem_age;
    if (alu_load && mem_load) begin
      alu_age_n = 1'b1;
      mem_age_n = 1'b0;
    end else if (alu_load) begin
      alu_age_n = !(mem_full && !grant_mem);
      mem_age_n = mem_full && !grant_mem;
    end else if (mem_load) begin
      alu_age_n = alu_full && !grant_alu;
      mem_age_n = !(alu_full && !grant_alu);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= LAST_ALU;
      write_en_o   <= 1'b0;
      write_addr_o <= '0;
      write_data_o <= '0;
    end else begin
      if (grant_alu) begin
        state_q      <= LAST_ALU;
        write_en_o   <= 1'b1;
        write_addr_o <= alu_addr_q;
        write_data_o <= alu_data_q;
      end else if (grant_mem) begin
        state_q      <= LAST_MEM;
        write_en_o   <= 1'b1;
        write_addr_o <= mem_addr_q;
        write_data_o <= mem_data_q;
      end else begin
        write_en_o <= 1'b0;
      end
    end
  end

  always_comb begin
    pending_mask_o = '0;
    if (alu_full)   pending_mask_o[alu_addr_q]   = 1'b1;
    if (mem_full)   pending_mask_o[mem_addr_q]   = 1'b1;
    if (write_en_o) pending_mask_o[write_addr_o] = 1'b1;
  end

  assign idle_o = !(alu_full || mem_full || write_en_o);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios plus random traffic, all
// compared against a sequence-numbered reference model of the write path.
module tb_reg_write_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        alu_valid_i, mem_valid_i;
  logic        alu_ready_o, mem_ready_o;
  logic [3:0]  alu_addr_i, mem_addr_i;
  logic [31:0] alu_data_i, mem_data_i;
  logic        write_en_o;
  logic [3:0]  write_addr_o;
  logic [31:0] write_data_o;
  logic [15:0] pending_mask_o;
  logic        idle_o;

  reg_write_arbiter #(.ADDR_WIDTH(4), .WORD(32)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .alu_valid_i    (alu_valid_i),
    .alu_ready_o    (alu_ready_o),
    .alu_addr_i     (alu_addr_i),
    .alu_data_i     (alu_data_i),
    .mem_valid_i    (mem_valid_i),
    .mem_ready_o    (mem_ready_o),
    .mem_addr_i     (mem_addr_i),
    .mem_data_i     (mem_data_i),
    .write_en_o     (write_en_o),
    .write_addr_o   (write_addr_o),
    .write_data_o   (write_data_o),
    .pending_mask_o (pending_mask_o),
    .idle_o         (idle_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: each held request carries a global arrival number, so
  // "older" is just a smaller number; fairness is remembered as who won last.
  bit          ma_v, mm_v;
  logic [3:0]  ma_a, mm_a;
  logic [31:0] ma_d, mm_d;
  int unsigned ma_s, mm_s, seq;
  bit          last_was_mem;
  bit          e_en;
  logic [3:0]  e_addr;
  logic [31:0] e_data;
  logic [31:0] model_rf [16];
  logic [31:0] dut_rf   [16];

  function automatic int model_grant();
    if (ma_v && mm_v) begin
      if (ma_a == mm_a) return (ma_s < mm_s) ? 1 : 2;
      return last_was_mem ? 1 : 2;
    end
    if (ma_v) return 1;
    if (mm_v) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    ma_v = 0; mm_v = 0; last_was_mem = 0;
    e_en = 0; e_addr = '0; e_data = '0;
  endtask

  task automatic model_step(input bit r, input bit av, input logic [3:0] aa, input logic [31:0] ad,
                            input bit mv, input logic [3:0] ma, input logic [31:0] md);
    int  g;
    bit  acc_a, acc_m;
    if (r) begin
      model_reset();
      return;
    end
    g     = model_grant();
    acc_a = av && (!ma_v || g == 1);
    acc_m = mv && (!mm_v || g == 2);
    if (g == 1) begin
      e_en = 1; e_addr = ma_a; e_data = ma_d; model_rf[ma_a] = ma_d;
      ma_v = 0; last_was_mem = 0;
    end else if (g == 2) begin
      e_en = 1; e_addr = mm_a; e_data = mm_d; model_rf[mm_a] = mm_d;
      mm_v = 0; last_was_mem = 1;
    end else begin
      e_en = 0;
    end
    if (acc_a) begin ma_v = 1; ma_a = aa; ma_d = ad; ma_s = seq; seq++; end
    if (acc_m) begin mm_v = 1; mm_a = ma; mm_d = md; mm_s = seq; seq++; end
  endtask

  // One clock cycle: drive, compare outputs mid-cycle, advance DUT and model.
  task automatic cycle(input bit r, input bit av, input logic [3:0] aa, input logic [31:0] ad,
                       input bit mv, input logic [3:0] ma, input logic [31:0] md);
    int          g;
    logic [15:0] pm;
    rst_i = r;
    alu_valid_i = av; alu_addr_i = aa; alu_data_i = ad;
    mem_valid_i = mv; mem_addr_i = ma; mem_data_i = md;
    #1;
    g  = model_grant();
    pm = '0;
    if (ma_v) pm[ma_a]   = 1'b1;
    if (mm_v) pm[mm_a]   = 1'b1;
    if (e_en) pm[e_addr] = 1'b1;
    check_val("alu_ready", alu_ready_o, !r && (!ma_v || g == 1));
    check_val("mem_ready", mem_ready_o, !r && (!mm_v || g == 2));
    check_val("write_en", write_en_o, e_en);
    check_val("write_addr", write_addr_o, e_addr);
    check_val("write_data", write_data_o, e_data);
    check_val("pending", pending_mask_o, pm);
    check_val("idle", idle_o, !(ma_v || mm_v || e_en));
    if (write_en_o === 1'b1) dut_rf[write_addr_o] = write_data_o;
    @(posedge clk_i);
    #1;
    model_step(r, av, aa, ad, mv, ma, md);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0);
  endtask

  initial begin
    logic [31:0] rnd;
    bit          rr, av, mv;
    logic [3:0]  aa, ma;

    for (int i = 0; i < 16; i++) begin model_rf[i] = '0; dut_rf[i] = '0; end
    seq = 0;
    model_reset();
    rst_i = 1; alu_valid_i = 0; mem_valid_i = 0;
    alu_addr_i = '0; mem_addr_i = '0; alu_data_i = '0; mem_data_i = '0;
    @(posedge clk_i);
    #1;
    cycle(1, 1, 4'd2, 32'h5, 1, 4'd3, 32'h6);
    cycle(1, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0);

    // Single ALU write: visible two cycles after the handshake.
    cycle(0, 1, 4'd3, 32'h11, 0, 4'd0, 32'd0);
    check_val("r23_pend_c1", pending_mask_o[3], 1'b1);
    cycle(0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0);
    check_val("r23_we_c2", write_en_o, 1'b1);
    check_val("r23_addr_c2", write_addr_o, 4'd3);
    check_val("r23_data_c2", write_data_o, 32'h11);
    check_val("r23_pend_c2", pending_mask_o[3], 1'b1);
    cycle(0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0);
    check_val("r23_idle_c3", idle_o, 1'b1);

    // Both requesters held continuously on distinct registers.
    for (int i = 0; i < 8; i++) cycle(0, 1, 4'd1, 32'hA, 1, 4'd2, 32'hB);
    idle_cycles(4);

    // Same register in the same cycle: ALU first, mem value wins.
    cycle(0, 1, 4'd5, 32'h1, 1, 4'd5, 32'h2);
    cycle(0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0);
    check_val("r25_first", write_data_o, 32'h1);
    cycle(0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0);
    check_val("r25_second", write_data_o, 32'h2);
    idle_cycles(2);
    check_val("r25_final", dut_rf[5], 32'h2);

    // Leave the arbiter in LAST_MEM, then mem before ALU on one register.
    cycle(0, 0, 4'd0, 32'd0, 1, 4'd9, 32'h99);
    idle_cycles(3);
    cycle(0, 0, 4'd0, 32'd0, 1, 4'd7, 32'hC);
    cycle(0, 1, 4'd7, 32'hD, 0, 4'd0, 32'd0);
    check_val("r26_mem_first", write_data_o, 32'hC);
    cycle(0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0);
    check_val("r26_alu_second", write_data_o, 32'hD);
    idle_cycles(2);

    // Sustained ALU stream.
    for (int i = 0; i < 8; i++) cycle(0, 1, 4'd4, 32'h100 + i, 0, 4'd0, 32'd0);
    idle_cycles(3);

    // Reset pulse with both slots full.
    cycle(0, 1, 4'd6, 32'h61, 1, 4'd8, 32'h81);
    cycle(0, 1, 4'd6, 32'h62, 1, 4'd8, 32'h82);
    cycle(1, 1, 4'd6, 32'h63, 1, 4'd8, 32'h83);
    check_val("r28_we", write_en_o, 1'b0);
    check_val("r28_pend", pending_mask_o, 16'h0);
    cycle(0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0);
    idle_cycles(2);

    // Random traffic with frequent address collisions and rare resets.
    for (int i = 0; i < 3000; i++) begin
      rnd = $urandom;
      rr  = ($urandom_range(0, 63) == 0);
      av  = ($urandom_range(0, 9) < 7);
      mv  = ($urandom_range(0, 9) < 7);
      aa  = rnd[0] ? {2'b00, rnd[2:1]} : rnd[6:3];
      ma  = rnd[7] ? {2'b00, rnd[9:8]} : rnd[13:10];
      cycle(rr, av, aa, $urandom, mv, ma, $urandom);
    end
    idle_cycles(4);

    for (int i = 0; i < 16; i++) check_val($sformatf("regfile_%0d", i), dut_rf[i], model_rf[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
